// File: rtl/truth_table_sweeper_pkg.sv
// truth_table_sweeper_pkg: shared FSM state type, table bit mapping and default expected word.
package truth_table_pkg;

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, REPORT} tts_state_e;

    localparam logic [7:0] TTS_DEFAULT_EXPECTED = 8'hFC;

    // Combo 0 lands on the MSB, so a table reads left to right in combo order.
    function automatic int tt_index(input int combo, input int n_in);
        return (1 << n_in) - 1 - combo;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: control, gate-drive and result handshake bundle for the sweeper.
//   master: test/control side plus gate model (drives start, abort, dut_out, result_ready)
//   slave : the sweeper (drives dut_in, busy, table_out, match, unstable, result_valid)
interface truth_table_sweeper_if #(parameter int N_IN = 3);
    logic                 start;
    logic                 abort;
    logic [N_IN-1:0]      dut_in;
    logic                 dut_out;
    logic                 busy;
    logic [2**N_IN-1:0]   table_out;
    logic                 match;
    logic                 unstable;
    logic                 result_valid;
    logic                 result_ready;
    modport master (
        output start, abort, dut_out, result_ready,
        input  dut_in, busy, table_out, match, unstable, result_valid
    );
    modport slave (
        input  start, abort, dut_out, result_ready,
        output dut_in, busy, table_out, match, unstable, result_valid
    );
endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// tts_settle_timer: loadable down-counter that stops at zero and flags it.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : load load_val_i (wins over en_i)
//   en_i        : decrement while non-zero
//   zero_o      : count is zero
module tts_settle_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (load_i) cnt_q <= load_val_i;
        else if (en_i && cnt_q != '0) cnt_q <= cnt_q - W'(1);
    end
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks a gate through every input combo, samples its output and reports the truth table.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : truth_table_sweeper_if.slave (start/abort, dut_in/dut_out, results + valid/ready)
//   Optional TTS_STABILITY_CHECK_EN: flag outputs that move during settle and force match low.
module truth_table_sweeper import truth_table_pkg::*; #(
    parameter int                 N_IN          = 3,
    parameter int                 SETTLE_CYCLES = 4,
    parameter logic [2**N_IN-1:0] EXPECTED      = TTS_DEFAULT_EXPECTED
) (
    input logic                   clk,
    input logic                   rst_n,
    truth_table_sweeper_if.slave  bus
);
    localparam int TW = 2**N_IN;
    localparam int CW = N_IN + 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    tts_state_e      state_q, state_d;
    logic [CW-1:0]   combo_q;
    logic [TW-1:0]   shadow_q, table_q;
    logic [N_IN-1:0] dut_in_q, bit_idx;
    logic            match_q, unstable_q, valid_q;
    logic            busy, settle_zero, last_combo, report_entry, unst_flag;

    assign last_combo   = combo_q == CW'(TW - 1);
    // Results are latched on the first REPORT cycle; valid_q marks that it already happened.
    assign report_entry = state_q == REPORT && !valid_q;
    assign bit_idx      = N_IN'(tt_index(int'(combo_q), N_IN));

    tts_settle_timer #(.W(SW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (state_q == DRIVE),
        .en_i       (state_q == SETTLE),
        .load_val_i (SW'(SETTLE_CYCLES - 1)),
        .zero_o     (settle_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start ? DRIVE : IDLE;
            DRIVE:   state_d = SETTLE;
            SETTLE:  state_d = settle_zero ? SAMPLE : SETTLE;
            SAMPLE:  state_d = last_combo ? REPORT : DRIVE;
            REPORT:  state_d = (valid_q && bus.result_ready) ? IDLE : REPORT;
            default: state_d = IDLE;
        endcase
        if (busy && bus.abort) state_d = IDLE;
    end

    always_comb begin
        busy = state_q inside {DRIVE, SETTLE, SAMPLE};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            combo_q    <= '0;
            shadow_q   <= '0;
            dut_in_q   <= '0;
            table_q    <= '0;
            match_q    <= 1'b0;
            unstable_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                combo_q  <= '0;
                shadow_q <= '0;
            end
            if (state_q == DRIVE) dut_in_q <= combo_q[N_IN-1:0];
            if (state_q == SAMPLE) begin
                shadow_q[bit_idx] <= bus.dut_out;
                combo_q           <= combo_q + CW'(1);
            end
            if (report_entry) begin
                table_q    <= shadow_q;
                match_q    <= shadow_q == EXPECTED && !unst_flag;
                unstable_q <= unst_flag;
                valid_q    <= 1'b1;
            end
            if (state_q == REPORT && valid_q && bus.result_ready) valid_q <= 1'b0;
            if (busy && bus.abort) dut_in_q <= '0;
        end
    end

`ifdef TTS_STABILITY_CHECK_EN
    logic ref_q, unst_q, drv_q, diff;
    // drv_q marks the first SETTLE cycle of a combo, where the reference value is captured.
    assign diff = ((state_q == SETTLE && !drv_q) || state_q == SAMPLE) && bus.dut_out != ref_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q  <= 1'b0;
            unst_q <= 1'b0;
            drv_q  <= 1'b0;
        end else begin
            drv_q <= state_q == DRIVE;
            if (state_q == SETTLE && drv_q) ref_q <= bus.dut_out;
            if (state_q == IDLE) unst_q <= 1'b0;
            else if (diff) unst_q <= 1'b1;
        end
    end
    assign unst_flag = unst_q;
`else
    assign unst_flag = 1'b0;
`endif

    assign bus.dut_in       = dut_in_q;
    assign bus.busy         = busy;
    assign bus.table_out    = table_q;
    assign bus.match        = match_q;
    assign bus.unstable     = unstable_q;
    assign bus.result_valid = valid_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: table-driven gate sweeps with a result scoreboard plus stall, abort, reset and glitch sequences.
module tb_truth_table_sweeper;
    typedef struct { logic [2:0] g; logic [7:0] tbl; logic m; } vec_t;
    typedef struct { logic [7:0] tbl; logic m; logic u; } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] gate_sel = 3'd0;
    logic       glitch = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    exp_t       sb[$];
    vec_t       vecs[5];

    truth_table_sweeper_if #(.N_IN(3)) bus();
    truth_table_sweeper dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // 0: NAND(in1,in2)  1: AND3  2: OR(in1,in2)  3: XOR3  4: constant 1
    function automatic logic gate(input logic [2:0] x, input logic [2:0] s);
        case (s)
            3'd0:    return ~(x[2] & x[1]);
            3'd1:    return &x;
            3'd2:    return x[2] | x[1];
            3'd3:    return ^x;
            default: return 1'b1;
        endcase
    endfunction

    assign bus.dut_out = gate(bus.dut_in, gate_sel) ^ glitch;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.result_valid && bus.result_ready) begin
            if (sb.size() == 0) check("unexpected_result", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("table_out", bus.table_out, e.tbl);
                check("match", bus.match, e.m);
                check("unstable", bus.unstable, e.u);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk) #1 bus.start = 1'b0;
    endtask

    task automatic run_sweep(input logic [2:0] g, input int gc, input logic [7:0] t, input logic m, input logic u);
        int   n = 0;
        logic walk_ok = 1'b1;
        logic busy_ok = 1'b1;
        gate_sel = g;
        sb.push_back(exp_t'{t, m, u});
        pulse_start();
        while (!bus.result_valid && n < 200) begin
            @(posedge clk) #1 n++;
            if (n == 6 * gc + 2) glitch = 1'b1;
            if (n == 6 * gc + 3) glitch = 1'b0;
            if (n <= 48 && bus.dut_in != 3'((n - 1) / 6)) walk_ok = 1'b0;
            if (n <= 48 && bus.busy != (n <= 47)) busy_ok = 1'b0;
        end
        check("latency", n, 49);
        check("dut_in_walk", walk_ok, 1);
        check("busy_window", busy_ok, 1);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb.size() != 0 && k < 30) begin
            @(posedge clk) #1 k++;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic ok;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.result_ready = 1'b1;
        vecs[0] = '{3'd1, 8'h01, 1'b0};
        vecs[1] = '{3'd2, 8'h3F, 1'b0};
        vecs[2] = '{3'd3, 8'h69, 1'b0};
        vecs[3] = '{3'd4, 8'hFF, 1'b0};
        vecs[4] = '{3'd0, 8'hFC, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_dut_in", bus.dut_in, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_table", bus.table_out, 0);
        check("rst_match", bus.match, 0);
        check("rst_unstable", bus.unstable, 0);
        check("rst_valid", bus.result_valid, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_sweep(vecs[i].g, -1, vecs[i].tbl, vecs[i].m, 1'b0);
            wait_drain();
        end

        // Consumer stalls; a start during REPORT must be dropped.
        bus.result_ready = 1'b0;
        run_sweep(3'd0, -1, 8'hFC, 1'b1, 1'b0);
        ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 5) bus.start = 1'b1;
            @(posedge clk) #1 bus.start = 1'b0;
            if (!bus.result_valid || bus.table_out != 8'hFC || bus.busy) ok = 1'b0;
        end
        check("stall_hold", ok, 1);
        check("stall_pending", sb.size(), 1);
        bus.result_ready = 1'b1;
        wait_drain();
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk) #1;
            if (bus.busy || bus.result_valid) ok = 1'b0;
        end
        check("no_queued_sweep", ok, 1);

        // Abort during SETTLE of combo 5.
        gate_sel = 3'd1;
        pulse_start();
        n = 0;
        while (bus.dut_in != 3'd5 && n < 100) begin
            @(posedge clk) #1 n++;
        end
        check("reach_combo5", bus.dut_in, 5);
        bus.abort = 1'b1;
        @(posedge clk) #1 bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_dut_in", bus.dut_in, 0);
        check("abort_table", bus.table_out, 8'hFC);
        ok = 1'b1;
        repeat (60) begin
            @(posedge clk) #1;
            if (bus.result_valid || bus.busy) ok = 1'b0;
        end
        check("abort_no_result", ok, 1);

        // Asynchronous reset in the SAMPLE cycle of combo 2.
        gate_sel = 3'd0;
        pulse_start();
        repeat (17) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_dut_in", bus.dut_in, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_table", bus.table_out, 0);
        check("arst_match", bus.match, 0);
        check("arst_valid", bus.result_valid, 0);
        @(negedge clk) rst_n = 1'b1;
        run_sweep(3'd0, -1, 8'hFC, 1'b1, 1'b0);
        wait_drain();

        // Glitch during combo 2 settle, clean again by the sample point.
`ifdef TTS_STABILITY_CHECK_EN
        run_sweep(3'd0, 2, 8'hFC, 1'b0, 1'b1);
`else
        run_sweep(3'd0, 2, 8'hFC, 1'b1, 1'b0);
`endif
        wait_drain();

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
